// File: rtl/sdram_arbit.sv
// sdram_arbit: command arbiter and refresh scheduler for the SDRAM controller.
// It sequences power-up init, times periodic auto-refresh, grants the single
// command bus to one generator at a time (refresh first, write/read in
// round-robin) and muxes the granted generator's command, bank, address and
// write data onto the SDRAM pins.
//
// Ports
//   sys_clk, sys_rst              clock, synchronous active-high reset
//   init_end                      initialization complete (level)
//   init_cmd/ba/addr              init command bus
//   aref_cmd/ba/addr, aref_end    refresh command bus, refresh done pulse
//   wr_req, wr_cmd/ba/addr        write request and command bus
//   wr_data, wr_sdram_en, wr_end  write data, data phase active, done pulse
//   rd_req, rd_cmd/ba/addr,rd_end read request, command bus, done pulse
//   aref_req                      refresh pending (lets generators cut bursts)
//   aref_en, wr_en, rd_en         registered grants, one-hot or all zero
//   sdram_*                       device pins (cke, command, ba, addr, dq)

module sdram_arbit #(
  parameter int unsigned AREF_PERIOD = 750,
  parameter logic [3:0]  CMD_NOP     = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        aref_end,
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_sdram_en,
  input  logic        wr_end,
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  input  logic        rd_end,
  output logic        aref_req,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  localparam int unsigned CNT_W = (AREF_PERIOD > 2) ? $clog2(AREF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AREF_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } cmd_bus_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_tc;
  logic             aref_req_q, aref_req_d;
  logic             last_wr_q, last_wr_d;   // 1: last grant was write
  logic             aref_en_q, wr_en_q, rd_en_q;
  cmd_bus_t         bus_c;
  logic             dq_oe_c;

  // State register; grants are registered alongside the state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      aref_req_q <= 1'b0;
      last_wr_q  <= 1'b0;
      aref_en_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aref_req_q <= aref_req_d;
      last_wr_q  <= last_wr_d;
      aref_en_q  <= (state_d == ST_AREF);
      wr_en_q    <= (state_d == ST_WRITE);
      rd_en_q    <= (state_d == ST_READ);
    end
  end

  // Next-state: refresh wins, write/read alternate on a tie, no preemption.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req_q)             state_d = ST_AREF;
        else if (wr_req && rd_req)  state_d = last_wr_q ? ST_READ : ST_WRITE;
        else if (wr_req)            state_d = ST_WRITE;
        else if (rd_req)            state_d = ST_READ;
      end
      ST_AREF: begin
        if (aref_end) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (wr_end) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (rd_end) state_d = ST_ARBIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Refresh timer, pending flag and round-robin memory.
  // A terminal count landing on the same edge that consumes the pending
  // request re-arms it, so that refresh interval is never lost.
  always_comb begin
    cnt_tc     = (state_q != ST_INIT) && (cnt_q == CNT_MAX);
    cnt_d      = cnt_q + CNT_W'(1);
    aref_req_d = aref_req_q;
    last_wr_d  = last_wr_q;

    if (state_q == ST_INIT || cnt_tc) cnt_d = '0;

    if (cnt_tc)
      aref_req_d = 1'b1;
    else if (state_q == ST_ARBIT && state_d == ST_AREF)
      aref_req_d = 1'b0;

    if (state_q == ST_ARBIT && state_d == ST_WRITE) last_wr_d = 1'b1;
    if (state_q == ST_ARBIT && state_d == ST_READ)  last_wr_d = 1'b0;
  end

  // Output mux: zero-latency select of the granted command bus.
  always_comb begin
    bus_c   = '{cmd: CMD_NOP, ba: 2'b11, addr: 13'h1fff};
    dq_oe_c = 1'b0;
    case (state_q)
      ST_INIT:  bus_c = '{cmd: init_cmd, ba: init_ba, addr: init_addr};
      ST_AREF:  bus_c = '{cmd: aref_cmd, ba: aref_ba, addr: aref_addr};
      ST_WRITE: begin
        bus_c   = '{cmd: wr_cmd, ba: wr_ba, addr: wr_addr};
        dq_oe_c = wr_sdram_en;
      end
      ST_READ:  bus_c = '{cmd: rd_cmd, ba: rd_ba, addr: rd_addr};
      default:  bus_c = '{cmd: CMD_NOP, ba: 2'b11, addr: 13'h1fff};
    endcase
  end

  assign aref_req     = aref_req_q;
  assign aref_en      = aref_en_q;
  assign wr_en        = wr_en_q;
  assign rd_en        = rd_en_q;
  assign sdram_cke    = 1'b1;
  assign sdram_cs_n   = bus_c.cmd[3];
  assign sdram_ras_n  = bus_c.cmd[2];
  assign sdram_cas_n  = bus_c.cmd[1];
  assign sdram_we_n   = bus_c.cmd[0];
  assign sdram_ba     = bus_c.ba;
  assign sdram_addr   = bus_c.addr;
  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = dq_oe_c;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter and refresh scheduler that sits inside the SDRAM controller, between the init, auto-refresh, write and read command generators and the SDRAM pins. It does four things:
- Sequences power-up initialization.
- Times periodic auto-refresh.
- Grants the single SDRAM command bus to one submodule at a time, with refresh having priority and write/read alternating round-robin.
- Muxes the granted submodule's command, bank, address and write data onto the device.

## Interface
Parameters:
- AREF_PERIOD, 750: sys_clk cycles between refresh requests (7.5 us at 100 MHz).
- CMD_NOP, 4'b0111: {cs_n,ras_n,cas_n,we_n} NOP encoding.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- init_end  in  1  initialization complete (one-shot level, stays high).
- init_cmd / init_ba / init_addr  in  4 / 2 / 13  init command bus.
- aref_cmd / aref_ba / aref_addr  in  4 / 2 / 13  refresh command bus.
- aref_end  in  1  refresh sequence done (1-cycle pulse).
- wr_req  in  1  write burst pending.
- wr_cmd / wr_ba / wr_addr  in  4 / 2 / 13  write command bus.
- wr_data  in  16  write data.
- wr_sdram_en  in  1  write data phase active.
- wr_end  in  1  write burst done (pulse).
- rd_req  in  1  read burst pending.
- rd_cmd / rd_ba / rd_addr  in  4 / 2 / 13  read command bus.
- rd_end  in  1  read burst done (pulse).
- aref_req  out  1  refresh pending. Exported so write/read generators can terminate bursts early.
- aref_en / wr_en / rd_en  out  1 each  grants, one-hot or all zero.
- sdram_cke  out  1  clock enable.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins.
- sdram_ba  out  2  bank address.
- sdram_addr  out  13  row/column address.
- sdram_dq_out  out  16  write data to pad.
- sdram_dq_oe  out  1  pad output enable.

## Operation
State machine states: INIT, ARBIT, AREF, WRITE, READ.

Transitions:
- INIT -> ARBIT when init_end=1.
- ARBIT -> AREF if aref_req.
- ARBIT -> WRITE/READ otherwise, chosen by round-robin:
  - Only wr_req set -> WRITE.
  - Only rd_req set -> READ.
  - Both set -> the one not granted last (last_grant flag).
  - Neither set -> stay in ARBIT.
- AREF -> ARBIT on aref_end.
- WRITE -> ARBIT on wr_end.
- READ -> ARBIT on rd_end.
- *_end pulses arriving in a non-matching state are ignored.

Grants:
- aref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ).
- Grants are registered with the state.
- No preemption: a write or read runs until its *_end.

Refresh timer:
- Held at 0 while state==INIT.
- After init, counts 0..AREF_PERIOD-1 and wraps.
- At terminal count, sets aref_req.
- aref_req clears on the edge entering AREF.
- A second terminal count while aref_req is still set does not stack; aref_req stays 1.

last_grant:
- Updated on entry to WRITE (=W) or READ (=R).
- Reset value R, so write wins the first tie.

Output mux (combinational on state):
- INIT -> init_* bus.
- AREF -> aref_* bus.
- WRITE -> wr_* bus.
- READ -> rd_* bus.
- ARBIT -> CMD_NOP, ba=2'b11, addr=13'h1fff.
- sdram_cke = 1 constant.
- sdram_dq_out = wr_data.
- sdram_dq_oe = (state==WRITE) & wr_sdram_en.

Reset (sys_rst=1 at any time, including mid-burst) forces:
- state=INIT, all grants 0, timer 0, aref_req 0, last_grant=R.
- Outputs follow the init_* bus.
- sdram_dq_oe = 0.

## Timing
- Reset values:
  - aref_req=0, aref_en=0, wr_en=0, rd_en=0, sdram_dq_oe=0, sdram_cke=1.
  - Command, ba and addr pins equal init_cmd, init_ba, init_addr.
- init_end sampled high at edge n -> ARBIT at n+1. The first grant is at n+2 at the earliest.
- A request sampled in ARBIT at edge k -> grant high from k+1.
- X_end sampled at edge m -> grant low and state=ARBIT at m+1, with NOP on the bus. The next grant is at m+2 at the earliest.
- Therefore at least one NOP cycle separates any two grants.
- aref_req rises the cycle after the timer's terminal count, i.e. AREF_PERIOD cycles after the previous wrap.
- Mux path has zero added latency: bus pins follow the granted submodule's inputs in the same cycle.

## Test plan
- Reset, then init_end at cycle 10, no requests -> ARBIT with NOP (4'b0111, ba=3, addr=1fff) from cycle 11. aref_req rises 750 cycles later, aref_en the cycle after. aref_end pulse -> back to ARBIT.
- wr_req and rd_req held high together, each *_end returned 20 cycles after grant -> grants alternate W, R, W, R with exactly one NOP cycle between them.
- aref_req and wr_req both set in ARBIT -> aref_en granted first, wr_en after aref_end + 1 ARBIT cycle. A write in progress when aref_req rises is not preempted.
- Hold a write grant for 1600 cycles (two timer wraps) -> aref_req stays 1 with no double count. Exactly one AREF follows wr_end.
- sys_rst pulsed mid-WRITE with wr_sdram_en=1 -> next cycle state INIT, wr_en=0, dq_oe=0, aref_req=0. Stray wr_end/rd_end pulses in INIT/ARBIT cause no transition.
